// File: rtl/approx_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_err_monitor
//
// Consumer-side checker for approximate adder outputs. Each accepted sample
// {a, b, s} has its exact sum recomputed and its error distance
// ED = |(a+b) - s| folded into per-window statistics. After 2**WIN_LOG2
// samples one report is offered on a second valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle pulse, opens a window (honoured in IDLE only)
//   in_valid     sample valid
//   in_ready     sample accepted when in_valid & in_ready (registered)
//   in_a, in_b   operands, WIDTH bits
//   in_s         approximate sum under test, WIDTH+1 bits
//   busy         high while a window is being collected, drained or reported
//   rpt_valid    report valid
//   rpt_ready    report consumed when rpt_valid & rpt_ready
//   rpt_err_cnt  number of samples with ED != 0
//   rpt_sum_ed   sum of ED over the window
//   rpt_max_ed   largest ED in the window
// ---------------------------------------------------------------------------
module approx_err_monitor #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [WIDTH:0]            in_s,
  output logic                      busy,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [WIN_LOG2:0]         rpt_err_cnt,
  output logic [WIDTH+WIN_LOG2:0]   rpt_sum_ed,
  output logic [WIDTH:0]            rpt_max_ed
);

  localparam int SW = WIDTH + 1;             // sum / ED width
  localparam int CW = WIN_LOG2 + 1;          // sample counter width
  localparam int EW = WIDTH + 1 + WIN_LOG2;  // ED accumulator width

  // Count value of the final sample of a window.
  localparam logic [CW-1:0] WIN_LAST = CW'((64'd1 << WIN_LOG2) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  // Unsigned distance between two WIDTH+1 bit sums.
  function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y);
    logic [SW-1:0] d;
    if (x >= y) begin
      d = x - y;
    end else begin
      d = y - x;
    end
    return d;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic            in_ready_r;
  logic            busy_r;
  logic            rpt_valid_r;
  logic            accept_s;
  logic            last_accept_s;
  logic            open_win_s;

  logic            s1_vld_r;
  logic [SW-1:0]   s1_exact_r;
  logic [SW-1:0]   s1_approx_r;
  logic [SW-1:0]   ed_s;

  logic [CW-1:0]   err_cnt_r;
  logic [EW-1:0]   sum_ed_r;
  logic [SW-1:0]   max_ed_r;

  assign accept_s      = in_valid & in_ready_r;
  assign last_accept_s = accept_s & (cnt_r == WIN_LAST);
  assign open_win_s    = (state_r == ST_IDLE) & start;
  assign ed_s          = abs_diff(s1_exact_r, s1_approx_r);

  // Next-state logic of the window controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_accept_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        // S1 empty means the last sample has already reached the accumulators.
        if (!s1_vld_r) begin
          state_nxt_s = ST_REPORT;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_REPORT: begin
        if (rpt_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and registered handshake/status outputs decoded from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      rpt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_ACCUM);
      busy_r      <= (state_nxt_s != ST_IDLE);
      rpt_valid_r <= (state_nxt_s == ST_REPORT);
    end
  end

  // Accepted-sample counter for the current window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (open_win_s) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Stage 1: exact sum and captured approximate sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r    <= 1'b0;
      s1_exact_r  <= {SW{1'b0}};
      s1_approx_r <= {SW{1'b0}};
    end else if (accept_s) begin
      s1_vld_r    <= 1'b1;
      s1_exact_r  <= {1'b0, in_a} + {1'b0, in_b};
      s1_approx_r <= in_s;
    end else begin
      s1_vld_r    <= 1'b0;
      s1_exact_r  <= s1_exact_r;
      s1_approx_r <= s1_approx_r;
    end
  end

  // Stage 2: error statistics; cleared only when a window opens so the last
  // report stays readable in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {CW{1'b0}};
      sum_ed_r  <= {EW{1'b0}};
      max_ed_r  <= {SW{1'b0}};
    end else if (open_win_s) begin
      err_cnt_r <= {CW{1'b0}};
      sum_ed_r  <= {EW{1'b0}};
      max_ed_r  <= {SW{1'b0}};
    end else if (s1_vld_r) begin
      err_cnt_r <= err_cnt_r + {{(CW-1){1'b0}}, (ed_s != {SW{1'b0}})};
      sum_ed_r  <= sum_ed_r + {{WIN_LOG2{1'b0}}, ed_s};
      if (ed_s > max_ed_r) begin
        max_ed_r <= ed_s;
      end else begin
        max_ed_r <= max_ed_r;
      end
    end else begin
      err_cnt_r <= err_cnt_r;
      sum_ed_r  <= sum_ed_r;
      max_ed_r  <= max_ed_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign busy        = busy_r;
  assign rpt_valid   = rpt_valid_r;
  assign rpt_err_cnt = err_cnt_r;
  assign rpt_sum_ed  = sum_ed_r;
  assign rpt_max_ed  = max_ed_r;

endmodule

// File: tb/tb_approx_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_approx_err_monitor
//
// Bench for approx_err_monitor with WIDTH=16, WIN_LOG2=2 (window of 4).
// The stimulus side pushes the expected report of each window into a queue;
// an independent monitor compares every presented report against the head
// of that queue and pops it on the handshake.
// ---------------------------------------------------------------------------
module tb_approx_err_monitor;

  localparam int WIDTH    = 16;
  localparam int WIN_LOG2 = 2;
  localparam int WIN      = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_a;
  logic [WIDTH-1:0]        in_b;
  logic [WIDTH:0]          in_s;
  logic                    busy;
  logic                    rpt_valid;
  logic                    rpt_ready;
  logic [WIN_LOG2:0]       rpt_err_cnt;
  logic [WIDTH+WIN_LOG2:0] rpt_sum_ed;
  logic [WIDTH:0]          rpt_max_ed;

  approx_err_monitor #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_s        (in_s),
    .busy        (busy),
    .rpt_valid   (rpt_valid),
    .rpt_ready   (rpt_ready),
    .rpt_err_cnt (rpt_err_cnt),
    .rpt_sum_ed  (rpt_sum_ed),
    .rpt_max_ed  (rpt_max_ed)
  );

  typedef struct packed {
    logic [31:0] err;
    logic [31:0] sum;
    logic [31:0] mx;
  } rpt_t;

  rpt_t exp_q[$];
  int   n_chk;
  int   n_fail;

  logic [15:0] va [WIN];
  logic [15:0] vb [WIN];
  logic [16:0] vs [WIN];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: ED statistics from plain integer arithmetic.
  function automatic rpt_t model();
    rpt_t r;
    int   e;
    int   s;
    int   m;
    int   d;
    e = 0; s = 0; m = 0;
    for (int i = 0; i < WIN; i++) begin
      d = (int'(va[i]) + int'(vb[i])) - int'(vs[i]);
      if (d < 0) d = -d;
      if (d != 0) e = e + 1;
      s = s + d;
      if (d > m) m = d;
    end
    r.err = 32'(e);
    r.sum = 32'(s);
    r.mx  = 32'(m);
    return r;
  endfunction

  // Report monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    if (rst_n && rpt_valid) begin
      if (exp_q.size() == 0) begin
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL unexpected_report: got err=%0d sum=%0d max=%0d, expected no report",
                 rpt_err_cnt, rpt_sum_ed, rpt_max_ed);
      end else begin
        check("rpt_err_cnt", 32'(rpt_err_cnt), exp_q[0].err);
        check("rpt_sum_ed",  32'(rpt_sum_ed),  exp_q[0].sum);
        check("rpt_max_ed",  32'(rpt_max_ed),  exp_q[0].mx);
        if (rpt_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drive n samples from va/vb/vs until all are accepted (bounded).
  task automatic send_samples(input int n, input bit toggle);
    int idx;
    int guard;
    int phase;
    idx = 0; guard = 0; phase = 0;
    while (idx < n && guard < 200) begin
      @(posedge clk); #1;
      in_valid = toggle ? ((phase % 2) == 0) : 1'b1;
      phase = phase + 1;
      in_a = va[idx];
      in_b = vb[idx];
      in_s = vs[idx];
      @(negedge clk);
      if (in_valid && in_ready) idx = idx + 1;
      guard = guard + 1;
    end
    if (idx < n) check("accept_timeout", 32'(idx), 32'(n));
  endtask

  task automatic open_window();
    // start together with a valid sample: it must not be taken.
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b1;
    in_a = va[0]; in_b = vb[0]; in_s = vs[0];
    @(negedge clk);
    check("in_ready_at_start", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic run_window(input bit toggle, input bit hold_rpt);
    rpt_t e;
    int   guard;
    e = model();
    exp_q.push_back(e);
    rpt_ready = !hold_rpt;
    open_window();
    send_samples(WIN, toggle);
    // Extra offered samples after the window must all be refused.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      @(negedge clk);
      check("in_ready_after_window", 32'(in_ready), 32'd0);
      check("busy_after_window", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (hold_rpt) begin
      guard = 0;
      while (!rpt_valid && guard < 50) begin
        @(negedge clk);
        guard = guard + 1;
      end
      check("rpt_valid_appears", 32'(rpt_valid), 32'd1);
      // Held for 5 cycles; the monitor re-checks the values every cycle.
      repeat (5) @(negedge clk);
      check("rpt_valid_held", 32'(rpt_valid), 32'd1);
      @(posedge clk); #1;
      rpt_ready = 1'b1;
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard = guard + 1;
    end
    check("report_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rpt_valid", 32'(rpt_valid), 32'd0);
    check("idle_hold_err", 32'(rpt_err_cnt), e.err);
    check("idle_hold_sum", 32'(rpt_sum_ed), e.sum);
    check("idle_hold_max", 32'(rpt_max_ed), e.mx);
  endtask

  task automatic set_sample(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic [16:0] s);
    va[i] = a; vb[i] = b; vs[i] = s;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),    32'd0);
    check({tag, "_busy"},      32'(busy),        32'd0);
    check({tag, "_rpt_valid"}, 32'(rpt_valid),   32'd0);
    check({tag, "_err_cnt"},   32'(rpt_err_cnt), 32'd0);
    check({tag, "_sum_ed"},    32'(rpt_sum_ed),  32'd0);
    check({tag, "_max_ed"},    32'(rpt_max_ed),  32'd0);
  endtask

  initial begin
    logic [16:0] ex;
    logic [16:0] mask;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; rpt_ready = 1'b1;
    in_a = 16'h0000; in_b = 16'h0000; in_s = 17'h00000;
    #12;
    check_reset_outputs("reset");
    #10;
    rst_n = 1'b1;

    // 1. exact stream
    set_sample(0, 16'h1234, 16'h0FFF, 17'h02233);
    set_sample(1, 16'h0001, 16'h0002, 17'h00003);
    set_sample(2, 16'h8000, 16'h8000, 17'h10000);
    set_sample(3, 16'hABCD, 16'h0000, 17'h0ABCD);
    run_window(1'b0, 1'b0);

    // 2. low bits forced high
    for (int i = 0; i < WIN; i++) set_sample(i, 16'h0000, 16'h0000, 17'h0000F);
    run_window(1'b0, 1'b0);

    // 3. error in both directions
    set_sample(0, 16'h0080, 16'h0080, 17'h000FF);
    set_sample(1, 16'h0008, 16'h0008, 17'h00030);
    set_sample(2, 16'h1111, 16'h2222, 17'h03333);
    set_sample(3, 16'hFFFF, 16'h0001, 17'h10000);
    run_window(1'b0, 1'b0);

    // 4. backpressure on both handshakes
    set_sample(0, 16'h0010, 16'h0020, 17'h00031);
    set_sample(1, 16'h0100, 16'h0100, 17'h00200);
    set_sample(2, 16'h0FFF, 16'h0001, 17'h00F00);
    set_sample(3, 16'h0005, 16'h0005, 17'h00000);
    run_window(1'b1, 1'b1);

    // 5. maximum error distance
    for (int i = 0; i < WIN; i++) set_sample(i, 16'hFFFF, 16'hFFFF, 17'h00000);
    run_window(1'b0, 1'b0);

    // 6. asynchronous reset mid-window, then a clean window
    set_sample(0, 16'h0000, 16'h0000, 17'h000FF);
    set_sample(1, 16'h0003, 16'h0004, 17'h00100);
    open_window();
    send_samples(2, 1'b0);
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk); #2;
    rst_n = 1'b1;
    set_sample(0, 16'h0100, 16'h0200, 17'h00301);
    set_sample(1, 16'h0100, 16'h0200, 17'h00300);
    set_sample(2, 16'h7FFF, 16'h0001, 17'h07F00);
    set_sample(3, 16'h0000, 16'h0001, 17'h00000);
    run_window(1'b0, 1'b0);

    // Randomized windows
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < WIN; i++) begin
        va[i] = 16'($urandom);
        vb[i] = 16'($urandom);
        ex    = {1'b0, va[i]} + {1'b0, vb[i]};
        mask  = 17'($urandom_range(0, 255));
        case ($urandom_range(0, 2))
          0:       vs[i] = ex;
          1:       vs[i] = ex ^ mask;
          default: vs[i] = 17'($urandom);
        endcase
      end
      run_window(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
